seq_alu: RTL and testbench

- Clocked, parametrised successor to the combinational switch/button ALU.
- Debounces the five board buttons and latches the SW operands on a debounced press.
- Runs the selected operation over multiple cycles: bit-serial leading-ones and ones-count, single-cycle add/sub, signed shift-add multiply.
- Drives a registered result on LED plus a BUSY flag; sits between board I/O and LEDs.

---
 rtl/seq_alu_pkg.sv | 46 ++++
 rtl/seq_alu_if.sv | 32 +++
 rtl/seq_alu_btn_debounce.sv | 63 ++++++
 rtl/seq_alu.sv | 148 ++++++++++++++
 tb/tb_seq_alu.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_pkg
//  Purpose  : Shared types and constants for the sequential switch/button ALU.
//             It holds the operation and FSM state enums, the button priority
//             table and a helper that picks the winning operation when more
//             than one press pulse arrives in the same cycle.
//  Revision : 1.0  - initial release
// ============================================================================
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_LO   = 3'd0,   // leading-ones position
        OP_NO   = 3'd1,   // number of ones
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MULT = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int c_NUM_BTNS = 5;

    // Button vector index -> operation; index 0 is the highest priority.
    // Index order: 0=BTNC, 1=BTNU, 2=BTND, 3=BTNL, 4=BTNR.
    localparam op_t c_BTN_PRIO_OP [c_NUM_BTNS] = '{OP_MULT, OP_LO, OP_NO, OP_ADD, OP_SUB};

    // Lowest set index wins. Scanning from the low-priority end lets each
    // higher-priority hit overwrite the previous choice.
    function automatic op_t pick_op(input logic [c_NUM_BTNS-1:0] press);
        op_t op;
        op = c_BTN_PRIO_OP[c_NUM_BTNS-1];
        for (int i = c_NUM_BTNS - 1; i >= 0; i--) begin
            if (press[i]) begin
                op = c_BTN_PRIO_OP[i];
            end
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_if
//  Purpose  : Board-side bus of the sequential ALU: switch operands, the five
//             push buttons, the LED result and the BUSY flag.
//  Ports    : master - board/stimulus side (drives SW and buttons)
//             slave  - ALU side (drives LED and BUSY)
//  Revision : 1.0  - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int BITS = 16
);
    logic [BITS-1:0] SW;
    logic            BTNC;
    logic            BTNU;
    logic            BTND;
    logic            BTNL;
    logic            BTNR;
    logic [BITS-1:0] LED;
    logic            BUSY;

    modport master (
        output SW, BTNC, BTNU, BTND, BTNL, BTNR,
        input  LED, BUSY
    );

    modport slave (
        input  SW, BTNC, BTNU, BTND, BTNL, BTNR,
        output LED, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Front end for one push button: 2-flop synchroniser, debounce
//             counter and rising-edge detector producing a 1-cycle press pulse.
//  Ports    : clk      in  clock
//             rst_n    in  asynchronous active-low reset
//             btn_i    in  raw asynchronous button level
//             press_o  out 1-cycle pulse on a debounced press
//  Revision : 1.0  - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int c_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic               sync1_q;
    logic               sync2_q;
    logic               stable_q;
    logic               stable_d;
    logic               stable_prev_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; a single agreeing cycle restarts the qualification.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == c_CNT_W'(DB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = stable_q & ~stable_prev_q;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Clocked switch/button ALU. Debounced button presses latch the
//             switch operands and start a multi-cycle operation; the result
//             is registered onto LED and BUSY flags the operation in flight.
//  Ports    : CLK100MHZ   in  system clock
//             CPU_RESETN  in  asynchronous active-low reset
//             bus (slave) SW/BTN* in, LED/BUSY out (see seq_alu_if)
//  Revision : 1.0  - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int DB_CYCLES = 500000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    seq_alu_if.slave   bus
);
    localparam int HALF    = BITS / 2;
    localparam int c_CNT_W = $clog2(BITS) + 1;

    logic [c_NUM_BTNS-1:0] btn_raw;
    logic [c_NUM_BTNS-1:0] press;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [c_CNT_W-1:0] last_cnt;
    logic [BITS-1:0]    opnd_q, opnd_d;    // captured SW, kept intact
    logic [BITS-1:0]    shift_q, shift_d;  // captured SW, consumed LSB first
    logic [BITS-1:0]    mcand_q, mcand_d;  // sign-extended A, shifted left
    logic [BITS-1:0]    acc_q, acc_d;
    logic [BITS-1:0]    led_q, led_d;
    logic [BITS-1:0]    a_ext;
    logic [BITS-1:0]    b_ext;

    // Index order must match c_BTN_PRIO_OP.
    assign btn_raw = {bus.BTNR, bus.BTNL, bus.BTND, bus.BTNU, bus.BTNC};

    generate
        for (genvar i = 0; i < c_NUM_BTNS; i++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_db (
                .clk     (CLK100MHZ),
                .rst_n   (CPU_RESETN),
                .btn_i   (btn_raw[i]),
                .press_o (press[i])
            );
        end
    endgenerate

    assign a_ext = {{HALF{opnd_q[BITS-1]}}, opnd_q[BITS-1:HALF]};
    assign b_ext = {{HALF{opnd_q[HALF-1]}}, opnd_q[HALF-1:0]};

    // Index of the final iteration for the running operation.
    always_comb begin
        last_cnt = '0;
        case (op_q)
            OP_LO, OP_NO: last_cnt = c_CNT_W'(BITS - 1);
            OP_MULT:      last_cnt = c_CNT_W'(HALF - 1);
            default:      last_cnt = '0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= S_IDLE;
            op_q    <= OP_LO;
            cnt_q   <= '0;
            opnd_q  <= '0;
            shift_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            shift_q <= shift_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        shift_d = shift_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        led_d   = led_q;

        case (state_q)
            S_IDLE: begin
                // Presses are only sampled here, so pulses while busy are lost.
                if (|press) begin
                    opnd_d  = bus.SW;
                    shift_d = bus.SW;
                    mcand_d = {{HALF{bus.SW[BITS-1]}}, bus.SW[BITS-1:HALF]};
                    acc_d   = '0;
                    cnt_d   = '0;
                    op_d    = pick_op(press);
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                case (op_q)
                    // Ascending scan: the last set bit seen is the highest.
                    OP_LO:   if (shift_q[0]) acc_d = BITS'(cnt_q) + BITS'(1);
                    OP_NO:   acc_d = acc_q + BITS'(shift_q[0]);
                    OP_ADD:  acc_d = a_ext + b_ext;
                    OP_SUB:  acc_d = a_ext - b_ext;
                    // B's MSB carries negative weight in two's complement.
                    OP_MULT: if (shift_q[0]) acc_d = (cnt_q == last_cnt) ? acc_q - mcand_q
                                                                          : acc_q + mcand_q;
                    default: acc_d = acc_q;
                endcase
                shift_d = shift_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == last_cnt) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                led_d   = acc_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.LED  = led_q;
    assign bus.BUSY = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu (BITS=16, DB_CYCLES=4).
//             Stimulus pushes expected results into a scoreboard; a monitor
//             pops them whenever an operation completes (BUSY falls).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_seq_alu;

    localparam int BITS = 16;
    localparam int HALF = BITS / 2;

    // Button masks, bit order {R,L,D,U,C}
    localparam logic [4:0] M_C = 5'b00001;
    localparam logic [4:0] M_U = 5'b00010;
    localparam logic [4:0] M_D = 5'b00100;
    localparam logic [4:0] M_L = 5'b01000;
    localparam logic [4:0] M_R = 5'b10000;

    typedef struct {
        logic [BITS-1:0] led;
        int              busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_alu_if #(.BITS(BITS)) bus ();

    seq_alu #(
        .BITS      (BITS),
        .DB_CYCLES (4)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .bus        (bus)
    );

    int              n_checks     = 0;
    int              n_fail       = 0;
    int              ops_seen     = 0;
    int              ops_expected = 0;
    logic [BITS-1:0] last_led     = '0;
    exp_t            sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: operation chosen by priority, result from plain arithmetic.
    function automatic exp_t model(input logic [4:0] mask, input logic [BITS-1:0] sw);
        exp_t e;
        int   a;
        int   b;
        int   r;
        a = int'($signed(sw[BITS-1:HALF]));
        b = int'($signed(sw[HALF-1:0]));
        if (mask[0]) begin
            e.led  = BITS'(a * b);
            e.busy = HALF + 1;
        end else if (mask[1]) begin
            r = 0;
            for (int i = 0; i < BITS; i++) if (sw[i]) r = i + 1;
            e.led  = BITS'(r);
            e.busy = BITS + 1;
        end else if (mask[2]) begin
            e.led  = BITS'($countones(sw));
            e.busy = BITS + 1;
        end else if (mask[3]) begin
            e.led  = BITS'(a + b);
            e.busy = 2;
        end else begin
            e.led  = BITS'(a - b);
            e.busy = 2;
        end
        return e;
    endfunction

    task automatic set_btns(input logic [4:0] m);
        bus.BTNC = m[0];
        bus.BTNU = m[1];
        bus.BTND = m[2];
        bus.BTNL = m[3];
        bus.BTNR = m[4];
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: BUSY still high after %0d cycles, expected low", n);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Press mask for 'hold' cycles; SW is scrambled after capture to prove it is ignored.
    task automatic run_op(input logic [4:0] mask, input logic [BITS-1:0] sw, input int hold);
        exp_t e;
        e = model(mask, sw);
        sb.push_back(e);
        ops_expected++;
        last_led = e.led;
        bus.SW = sw;
        @(posedge clk);
        #1;
        set_btns(mask);
        repeat (hold) @(posedge clk);
        #1;
        bus.SW = BITS'($urandom);
        set_btns(5'b0);
        wait_idle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    int              busy_cnt     = 0;
    bit              in_op        = 1'b0;
    logic [BITS-1:0] mon_prev_led = '0;
    exp_t            mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt     = 0;
            in_op        = 1'b0;
            mon_prev_led = '0;
        end else if (bus.BUSY) begin
            if (!in_op) begin
                in_op    = 1'b1;
                ops_seen++;
                busy_cnt = 0;
            end
            busy_cnt++;
            chk("led_hold_while_busy", bus.LED, mon_prev_led);
            if (busy_cnt == 64) begin
                n_checks++;
                n_fail++;
                $display("FAIL busy_timeout: BUSY high %0d cycles, expected at most %0d", busy_cnt, BITS + 1);
            end
        end else if (in_op) begin
            in_op = 1'b0;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_op: operation completed with LED=%0h, expected none", bus.LED);
            end else begin
                mon_e = sb.pop_front();
                chk("led_result", bus.LED, mon_e.led);
                chk("busy_cycles", busy_cnt, mon_e.busy);
            end
            mon_prev_led = bus.LED;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int              n;
        logic [4:0]      m;
        logic [BITS-1:0] sw;

        rst_n  = 1'b1;
        bus.SW = '1;
        set_btns(5'b0);
        #2 rst_n = 1'b0;

        // Reset held with switches high and buttons toggling.
        for (int i = 0; i < 8; i++) begin
            set_btns(i[0] ? 5'b11111 : 5'b00000);
            @(negedge clk);
            chk("reset_led", bus.LED, 0);
            chk("reset_busy", bus.BUSY, 0);
        end
        set_btns(5'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_led", bus.LED, 0);
        chk("post_reset_busy", bus.BUSY, 0);
        @(posedge clk);
        #1;

        // Directed operations
        run_op(M_L, 16'h0310, 10);
        run_op(M_R, 16'h7F80, 10);
        run_op(M_C, 16'h8080, 10);
        run_op(M_C, 16'hFF02, 10);
        run_op(M_C, 16'h7F7F, 10);
        run_op(M_U, 16'h0400, 10);
        run_op(M_U, 16'h0000, 10);
        run_op(M_D, 16'hF0F1, 10);

        // Same-cycle contention: MULT beats LO
        run_op(M_C | M_U, 16'hFF02, 10);

        // Bounces of 1..3 cycles must not start anything
        n = ops_seen;
        for (int g = 1; g <= 3; g++) begin
            bus.BTNU = 1'b1;
            repeat (g) @(posedge clk);
            #1 bus.BTNU = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("glitch_ops", ops_seen, n);
        chk("glitch_led", bus.LED, last_led);
        chk("glitch_busy", bus.BUSY, 0);

        // Long hold gives exactly one operation
        run_op(M_L, 16'h0505, 200);

        // BTND pressed while MULT is busy is dropped
        begin
            exp_t e;
            e = model(M_C, 16'h7F7F);
            sb.push_back(e);
            ops_expected++;
            last_led = e.led;
            bus.SW = 16'h7F7F;
            @(posedge clk);
            #1 set_btns(M_C);
            repeat (3) @(posedge clk);
            #1 set_btns(M_C | M_D);
            repeat (12) @(posedge clk);
            #1 set_btns(5'b0);
            wait_idle();
            chk("drop_busy_press_led", bus.LED, 16'h3F01);
        end

        // Reset in the middle of a MULT aborts it
        bus.SW = 16'h8080;
        @(posedge clk);
        #1 set_btns(M_C);
        n = 0;
        while (!bus.BUSY && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_busy_started", bus.BUSY, 1);
        ops_expected++;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_led_immediate", bus.LED, 0);
        chk("abort_busy_immediate", bus.BUSY, 0);
        set_btns(5'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        last_led = '0;
        repeat (20) @(negedge clk);
        chk("abort_led_after", bus.LED, 0);
        chk("abort_busy_after", bus.BUSY, 0);
        @(posedge clk);
        #1;
        run_op(M_C, 16'hFF02, 10);

        // Randomised operations, including multi-button presses
        for (int k = 0; k < 24; k++) begin
            m  = 5'($urandom_range(1, 31));
            sw = (k % 6 == 5) ? '0 : BITS'($urandom);
            run_op(m, sw, int'($urandom_range(10, 14)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("ops_count", ops_seen, ops_expected);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
